// File: rtl/load_register.sv
// Parallel-load data register for the MY8CPU datapath: captures IN on a rising
// clock edge when load is high, otherwise holds; nReset clears it asynchronously.
module load_register #(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  input  logic             clock,
  input  logic             nReset,
  input  logic             load
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = IN;
    end
  end

  // OUT is driven only by the flop, so IN and load never reach it combinationally.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      out_q <= RESET_VALUE;
    end else begin
      out_q <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_load_register.sv
// Directed bench for load_register: a vector table for load/hold behaviour plus
// hand-written sequences for asynchronous reset assertion and release.
module tb_load_register;

  logic [7:0] in_v;
  logic [7:0] out_v;
  logic       clock;
  logic       nReset;
  logic       load;

  int n_checks;
  int n_fail;

  typedef struct {
    string      name;
    logic       ld;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  load_register #(
    .WIDTH      (8),
    .RESET_VALUE(8'h00)
  ) dut (
    .IN    (in_v),
    .OUT   (out_v),
    .clock (clock),
    .nReset(nReset),
    .load  (load)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: OUT=%02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s: OUT=%02h", name, act);
    end
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] xval;
    n_checks = 0;
    n_fail   = 0;
    xval     = 8'bxxxx_xxxx;

    // Hold phase after reset, then load, continuous load and hold.
    vecs.push_back('{"hold_92_a",   1'b0, 8'h92, 8'h00});
    vecs.push_back('{"hold_92_b",   1'b0, 8'h92, 8'h00});
    vecs.push_back('{"hold_92_c",   1'b0, 8'h92, 8'h00});
    vecs.push_back('{"load_92",     1'b1, 8'h92, 8'h92});
    vecs.push_back('{"load_f0",     1'b1, 8'hF0, 8'hF0});
    vecs.push_back('{"hold_55",     1'b0, 8'h55, 8'hF0});
    vecs.push_back('{"hold_x",      1'b0, xval,  8'hF0});
    vecs.push_back('{"hold_a5",     1'b0, 8'hA5, 8'hF0});
    vecs.push_back('{"cont_01",     1'b1, 8'h01, 8'h01});
    vecs.push_back('{"cont_80",     1'b1, 8'h80, 8'h80});
    vecs.push_back('{"cont_ff",     1'b1, 8'hFF, 8'hFF});
    vecs.push_back('{"hold_00",     1'b0, 8'h00, 8'hFF});
    vecs.push_back('{"load_00",     1'b1, 8'h00, 8'h00});
    vecs.push_back('{"load_f0_end", 1'b1, 8'hF0, 8'hF0});

    // Reset asserted before any clock edge: OUT must clear immediately.
    nReset = 1'b1;
    load   = 1'b0;
    in_v   = 8'h00;
    #1 nReset = 1'b0;
    #1 check("reset_immediate", out_v, 8'h00);

    // Clock toggles with load=1 during reset; OUT must stay cleared.
    in_v = 8'h3C;
    load = 1'b1;
    @(posedge clock); #1;
    check("reset_holds_with_load", out_v, 8'h00);

    @(negedge clock);
    load   = 1'b0;
    in_v   = 8'h92;
    nReset = 1'b1;
    #1 check("release_no_change", out_v, 8'h00);

    prev = 8'h00;
    foreach (vecs[i]) begin
      @(negedge clock);
      load = vecs[i].ld;
      in_v = vecs[i].din;
      #1 check({vecs[i].name, "_pre_edge"}, out_v, prev);
      @(posedge clock); #1;
      check(vecs[i].name, out_v, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Asynchronous reset between edges while OUT=F0.
    @(negedge clock);
    load = 1'b0;
    #2 nReset = 1'b0;
    #1 check("async_reset_mid_cycle", out_v, 8'h00);

    in_v = 8'h55;
    load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("reset_dominates_load", out_v, 8'h00);
    end

    // Release between edges with load=1: first capture on the next edge.
    @(negedge clock);
    nReset = 1'b1;
    #1 check("release_mid_cycle", out_v, 8'h00);
    @(posedge clock); #1;
    check("first_load_after_release", out_v, 8'h55);

    // Reset asserted coincident with a rising edge and load=1 gives RESET_VALUE.
    @(negedge clock);
    in_v = 8'hC3;
    @(posedge clock);
    nReset = 1'b0;
    #1 check("reset_at_edge", out_v, 8'h00);
    @(negedge clock);
    nReset = 1'b1;
    load   = 1'b0;
    @(posedge clock); #1;
    check("hold_after_edge_reset", out_v, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
